// File: rtl/ram_arb_pkg.sv
// Shared types for the data-RAM port arbiter: widths, requester id, command payload.
package ram_arb_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 64;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      req_id_t           id;
   } cmd_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Two-master command/response bundle for the data-RAM port arbiter.
interface ram_port_arbiter_if;
   import ram_arb_pkg::*;

   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              rvalid0;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata
   );

endinterface

// File: rtl/ram_arb_grant.sv
// Two-way round-robin pick with a burst allowance; holds the last-winner and burst count.
module ram_arb_grant
   import ram_arb_pkg::*;
#(
   parameter int unsigned BURST = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0_c,
   output logic gnt1_c
);

   localparam int unsigned CNT_W = $clog2(BURST + 1);

   req_id_t          last_q;
   req_id_t          last_nxt;
   req_id_t          win;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_nxt;
   logic             keep;

   // A contest only stays with the last winner while a burst is in progress and under the limit;
   // with no burst running (after reset or an idle cycle) the other requester goes first.
   assign keep = (cnt_q != '0) && (cnt_q < CNT_W'(BURST));

   always_comb begin
      gnt0_c   = 1'b0;
      gnt1_c   = 1'b0;
      last_nxt = last_q;
      cnt_nxt  = '0;
      win      = last_q;

      if (req0 && req1) begin
         win = keep ? last_q : req_id_t'(~last_q);
      end else if (req0) begin
         win = REQ0;
      end else begin
         win = REQ1;
      end

      if (!reset && (req0 || req1)) begin
         gnt0_c = (win == REQ0);
         gnt1_c = (win == REQ1);
         if (win == last_q) begin
            cnt_nxt = (cnt_q < CNT_W'(BURST)) ? cnt_q + CNT_W'(1) : cnt_q;
         end else begin
            last_nxt = win;
            cnt_nxt  = CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= REQ1;
         cnt_q  <= '0;
      end else begin
         last_q <= last_nxt;
         cnt_q  <= cnt_nxt;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two masters onto the single-port data RAM: one registered command per cycle,
// read data routed back to the issuer two cycles after acceptance.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned BURST = 4
) (
   input  logic              clock,
   input  logic              reset,
   ram_port_arbiter_if.slave bus,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_write,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic gnt0_c;
   logic gnt1_c;
   logic xfer0;
   logic xfer1;
   cmd_t cmd_q;
   cmd_t cmd_nxt;
   logic cmd_valid_q;
   logic cmd_valid_nxt;
   logic rvalid0_q;
   logic rvalid1_q;

   ram_arb_grant #(.BURST(BURST)) u_grant (
      .clock  (clock),
      .reset  (reset),
      .req0   (bus.req0),
      .req1   (bus.req1),
      .gnt0_c (gnt0_c),
      .gnt1_c (gnt1_c)
   );

   assign xfer0 = bus.req0 & gnt0_c;
   assign xfer1 = bus.req1 & gnt1_c;

   // Command capture; fields hold their last value when nothing transfers.
   always_comb begin
      cmd_nxt       = cmd_q;
      cmd_valid_nxt = 1'b0;
      if (xfer0) begin
         cmd_nxt       = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0, id: REQ0};
         cmd_valid_nxt = 1'b1;
      end else if (xfer1) begin
         cmd_nxt       = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1, id: REQ1};
         cmd_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q       <= '{we: 1'b0, addr: '0, wdata: '0, id: REQ0};
         cmd_valid_q <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
      end else begin
         cmd_q       <= cmd_nxt;
         cmd_valid_q <= cmd_valid_nxt;
         rvalid0_q   <= cmd_valid_q & ~cmd_q.we & (cmd_q.id == REQ0);
         rvalid1_q   <= cmd_valid_q & ~cmd_q.we & (cmd_q.id == REQ1);
      end
   end

   // RAM side is driven straight from the command register; the RAM registers read data itself.
   assign ram_addr    = cmd_q.addr;
   assign ram_wdata   = cmd_q.wdata;
   assign ram_write   = cmd_valid_q & cmd_q.we;

   assign bus.gnt0    = gnt0_c;
   assign bus.gnt1    = gnt1_c;
   assign bus.rvalid0 = rvalid0_q;
   assign bus.rvalid1 = rvalid1_q;
   assign bus.rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter with a behavioural 256x64 RAM beside the DUT.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   typedef struct {
      bit          id;
      logic [63:0] data;
   } exp_t;

   logic clock;
   logic reset;
   int   checks;
   int   failures;
   exp_t exp_q[$];

   ram_port_arbiter_if bus0();
   ram_port_arbiter_if bus1();

   logic [ADDR_W-1:0] ram_addr0, ram_addr1;
   logic [DATA_W-1:0] ram_wdata0, ram_wdata1;
   logic              ram_write0, ram_write1;
   logic [DATA_W-1:0] ram_rdata0;
   logic [DATA_W-1:0] ram_rdata1;
   logic [DATA_W-1:0] mem [256];

   ram_port_arbiter #(.BURST(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus0),
      .ram_addr  (ram_addr0),
      .ram_wdata (ram_wdata0),
      .ram_write (ram_write0),
      .ram_rdata (ram_rdata0)
   );

   ram_port_arbiter #(.BURST(1)) dut_b1 (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus1),
      .ram_addr  (ram_addr1),
      .ram_wdata (ram_wdata1),
      .ram_write (ram_write1),
      .ram_rdata (ram_rdata1)
   );

   assign ram_rdata1 = '0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural RAM: write on falling edge, registered read on rising edge.
   always @(negedge clock) if (ram_write0) mem[ram_addr0] <= ram_wdata0;
   always @(posedge clock) ram_rdata0 <= mem[ram_addr0];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic set0(input logic r, input logic w, input logic [7:0] a, input logic [63:0] d);
      bus0.req0 = r; bus0.we0 = w; bus0.addr0 = a; bus0.wdata0 = d;
   endtask

   task automatic set1(input logic r, input logic w, input logic [7:0] a, input logic [63:0] d);
      bus0.req1 = r; bus0.we1 = w; bus0.addr1 = a; bus0.wdata1 = d;
   endtask

   task automatic expect_read(input bit id, input logic [63:0] d);
      exp_t e;
      e.id   = id;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Response monitor: every rvalid pulse must match the oldest outstanding read.
   always @(negedge clock) begin
      if (bus0.rvalid0 === 1'b1 || bus0.rvalid1 === 1'b1) begin
         if (bus0.rvalid0 && bus0.rvalid1) begin
            chk("rvalid_onehot", {bus0.rvalid1, bus0.rvalid0}, 2'b01);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_rvalid", {bus0.rvalid1, bus0.rvalid0}, 2'b00);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rvalid_id", 64'(bus0.rvalid1), 64'(e.id));
            chk("rdata", bus0.rdata, e.data);
         end
      end
   end

   initial begin
      bit b4;
      bit b1;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      for (int a = 0; a < 256; a++) mem[a] = '0;
      set0(0, 0, 8'h00, '0);
      set1(0, 0, 8'h00, '0);
      bus1.req0 = 0; bus1.we0 = 1; bus1.addr0 = 8'h01; bus1.wdata0 = 64'h11;
      bus1.req1 = 0; bus1.we1 = 1; bus1.addr1 = 8'h02; bus1.wdata1 = 64'h22;

      // Reset with idle inputs, then reset with both requesting.
      next_cycle();
      @(negedge clock);
      chk("rst_gnt", {bus0.gnt1, bus0.gnt0}, 2'b00);
      chk("rst_ram_write", ram_write0, 1'b0);
      chk("rst_rvalid", {bus0.rvalid1, bus0.rvalid0}, 2'b00);
      next_cycle();
      set0(1, 1, 8'h80, 64'hA0);
      set1(1, 1, 8'h81, 64'hA1);
      @(negedge clock);
      chk("rst_gnt_forced", {bus0.gnt1, bus0.gnt0}, 2'b00);

      next_cycle();
      reset = 1'b0;
      set0(0, 0, 8'h00, '0);
      set1(0, 0, 8'h00, '0);
      @(negedge clock);
      chk("post_rst_gnt", {bus0.gnt1, bus0.gnt0}, 2'b00);
      chk("post_rst_ram_write", ram_write0, 1'b0);
      chk("post_rst_rvalid", {bus0.rvalid1, bus0.rvalid0}, 2'b00);

      // Fairness: both held 16 cycles; BURST=4 gives 0000 1111 ..., BURST=1 alternates.
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         set0(1, 1, 8'h80, 64'hA0);
         set1(1, 1, 8'h81, 64'hA1);
         bus1.req0 = 1; bus1.req1 = 1;
         @(negedge clock);
         b4 = ((i / 4) % 2) == 1;
         b1 = (i % 2) == 1;
         chk($sformatf("fair_b4_%0d", i), {bus0.gnt1, bus0.gnt0}, b4 ? 2'b10 : 2'b01);
         chk($sformatf("fair_b1_%0d", i), {bus1.gnt1, bus1.gnt0}, b1 ? 2'b10 : 2'b01);
      end
      next_cycle();
      set0(0, 0, 8'h00, '0);
      set1(0, 0, 8'h00, '0);
      bus1.req0 = 0; bus1.req1 = 0;

      // Write 0x10 then read it back from master 0.
      next_cycle();
      set0(1, 1, 8'h10, 64'hDEADBEEF00000001);
      @(negedge clock);
      chk("wr10_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(1, 0, 8'h10, '0);
      expect_read(1'b0, 64'hDEADBEEF00000001);
      @(negedge clock);
      chk("wr10_ram_write", ram_write0, 1'b1);
      chk("wr10_ram_addr", ram_addr0, 8'h10);
      chk("wr10_ram_wdata", ram_wdata0, 64'hDEADBEEF00000001);
      chk("rd10_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(0, 0, 8'h00, '0);
      @(negedge clock);
      chk("rd10_ram_write", ram_write0, 1'b0);

      // Lone requester 1 for 10 cycles: no burst limit.
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         set1(1, 0, 8'h10, '0);
         expect_read(1'b1, 64'hDEADBEEF00000001);
         @(negedge clock);
         chk($sformatf("lone1_%0d", i), {bus0.gnt1, bus0.gnt0}, 2'b10);
      end
      next_cycle();
      set1(0, 0, 8'h00, '0);

      // Read-after-write hazard across masters.
      next_cycle();
      set0(1, 1, 8'h3F, 64'h1);
      @(negedge clock);
      chk("raw_wr_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(0, 0, 8'h00, '0);
      set1(1, 0, 8'h3F, '0);
      expect_read(1'b1, 64'h1);
      @(negedge clock);
      chk("raw_rd_gnt", {bus0.gnt1, bus0.gnt0}, 2'b10);
      next_cycle();
      set1(0, 0, 8'h00, '0);
      repeat (3) next_cycle();

      // Reset while a read sits in the command register: no response, no new grant.
      next_cycle();
      set0(1, 0, 8'h3F, '0);
      @(negedge clock);
      chk("rstrd_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(0, 0, 8'h00, '0);
      set1(1, 0, 8'h10, '0);
      reset = 1'b1;
      @(negedge clock);
      chk("rstrd_gnt_in_reset", {bus0.gnt1, bus0.gnt0}, 2'b00);
      next_cycle();
      reset = 1'b0;
      set1(0, 0, 8'h00, '0);
      @(negedge clock);
      chk("rstrd_no_rvalid", {bus0.rvalid1, bus0.rvalid0}, 2'b00);
      next_cycle();
      @(negedge clock);
      chk("rstrd_no_rvalid_late", {bus0.rvalid1, bus0.rvalid0}, 2'b00);

      // Reset while a write sits in the command register: the write still lands.
      next_cycle();
      set0(1, 1, 8'h05, 64'hAA);
      @(negedge clock);
      chk("rstwr_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(0, 0, 8'h00, '0);
      reset = 1'b1;
      @(negedge clock);
      chk("rstwr_ram_write", ram_write0, 1'b1);
      chk("rstwr_ram_addr", ram_addr0, 8'h05);
      next_cycle();
      reset = 1'b0;
      next_cycle();
      set0(1, 0, 8'h05, '0);
      expect_read(1'b0, 64'hAA);
      @(negedge clock);
      chk("rstwr_rd_gnt", {bus0.gnt1, bus0.gnt0}, 2'b01);
      next_cycle();
      set0(0, 0, 8'h00, '0);

      repeat (4) next_cycle();
      @(negedge clock);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
